// File: rtl/icache_pkg.sv
// Shared constants, address field helpers and FSM state encoding for the
// direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_W        = 12;
  localparam int unsigned INDEX_BITS    = 4;
  localparam int unsigned WORD_OFF_BITS = 2;
  localparam int unsigned CNT_W         = 16;

  localparam int unsigned NUM_LINES   = 1 << INDEX_BITS;
  localparam int unsigned LINE_WORDS  = 4;
  localparam int unsigned WORD_LSB    = 2;
  localparam int unsigned INDEX_LSB   = WORD_LSB + WORD_OFF_BITS;
  localparam int unsigned TAG_LSB     = INDEX_LSB + INDEX_BITS;
  localparam int unsigned TAG_BITS    = ADDR_W - TAG_LSB;
  localparam int unsigned LINE_ADDR_W = TAG_BITS + INDEX_BITS;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRefill = 2'd1,
    StUpdate = 2'd2
  } state_e;

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[TAG_LSB +: TAG_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[INDEX_LSB +: INDEX_BITS];
  endfunction

  function automatic logic [WORD_OFF_BITS-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[WORD_LSB +: WORD_OFF_BITS];
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Miss-handling controller: latches the missing line, walks its words in order
// over the memory handshake and defers flushes that arrive mid-refill.
module icache_refill_fsm
  import icache_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     miss_i,
  input  logic [LINE_ADDR_W-1:0]   line_addr_i,
  input  logic                     flush_i,
  input  logic                     mem_ready_i,
  output logic                     busy_o,
  output logic                     refill_start_o,
  output logic                     fill_we_o,
  output logic                     update_o,
  output logic                     update_flush_o,
  output logic [LINE_ADDR_W-1:0]   miss_addr_o,
  output logic [WORD_OFF_BITS-1:0] word_cnt_o,
  output logic                     mem_read_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o
);

  state_e                   state_q, state_d;
  logic [WORD_OFF_BITS-1:0] word_cnt_q, word_cnt_d;
  logic [LINE_ADDR_W-1:0]   miss_addr_q, miss_addr_d;
  logic                     flush_pending_q, flush_pending_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      word_cnt_q      <= '0;
      miss_addr_q     <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_cnt_q      <= word_cnt_d;
      miss_addr_q     <= miss_addr_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    word_cnt_d      = word_cnt_q;
    miss_addr_d     = miss_addr_q;
    flush_pending_d = flush_pending_q;
    refill_start_o  = 1'b0;
    fill_we_o       = 1'b0;
    update_o        = 1'b0;
    update_flush_o  = 1'b0;
    mem_read_req_o  = 1'b0;
    mem_addr_o      = '0;
    unique case (state_q)
      StIdle: begin
        if (miss_i) begin
          refill_start_o = 1'b1;
          miss_addr_d    = line_addr_i;
          word_cnt_d     = '0;
          state_d        = StRefill;
        end
      end
      StRefill: begin
        mem_read_req_o = 1'b1;
        mem_addr_o     = {miss_addr_q, word_cnt_q, 2'b00};
        if (flush_i) flush_pending_d = 1'b1;
        if (mem_ready_i) begin
          fill_we_o  = 1'b1;
          word_cnt_d = word_cnt_q + WORD_OFF_BITS'(1);
          if (word_cnt_q == WORD_OFF_BITS'(LINE_WORDS - 1)) state_d = StUpdate;
        end
      end
      StUpdate: begin
        update_o        = 1'b1;
        // A flush landing in this very cycle is honoured like a pending one.
        update_flush_o  = flush_pending_q | flush_i;
        flush_pending_d = 1'b0;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o      = (state_q != StIdle);
  assign miss_addr_o = miss_addr_q;
  assign word_cnt_o  = word_cnt_q;

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped 16-line x 4-word instruction cache with combinational hits,
// in-order line refill, fence.i flush and saturating hit/miss counters.
module icache_direct_mapped
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_read_req,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic [31:0]       icache_read_data,
  output logic              icache_stall,
  input  logic              icache_flush,
  output logic              mem_read_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned PtrW = INDEX_BITS + WORD_OFF_BITS;

  logic [31:0]                        data_q [NUM_LINES*LINE_WORDS];
  logic [NUM_LINES-1:0][TAG_BITS-1:0] tag_q, tag_d;
  logic [NUM_LINES-1:0]               valid_q, valid_d;
  logic [CNT_W-1:0]                   hit_count_q, hit_count_d;
  logic [CNT_W-1:0]                   miss_count_q, miss_count_d;

  logic [TAG_BITS-1:0]      req_tag;
  logic [INDEX_BITS-1:0]    req_idx;
  logic [WORD_OFF_BITS-1:0] req_word;
  logic                     hit, busy;
  logic                     refill_start, fill_we, update, update_flush;
  logic [LINE_ADDR_W-1:0]   miss_addr;
  logic [WORD_OFF_BITS-1:0] word_cnt;
  logic [INDEX_BITS-1:0]    miss_idx;
  logic [TAG_BITS-1:0]      miss_tag;
  logic [PtrW-1:0]          rd_ptr, wr_ptr;
  logic                     unused_byte_bits;

  assign req_tag          = addr_tag(icache_addr);
  assign req_idx          = addr_index(icache_addr);
  assign req_word         = addr_word(icache_addr);
  assign unused_byte_bits = ^icache_addr[WORD_LSB-1:0];

  assign miss_idx = miss_addr[INDEX_BITS-1:0];
  assign miss_tag = miss_addr[LINE_ADDR_W-1:INDEX_BITS];
  assign rd_ptr   = {req_idx, req_word};
  assign wr_ptr   = {miss_idx, word_cnt};

  assign hit              = icache_read_req & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign icache_read_data = hit ? data_q[rd_ptr] : '0;
  assign icache_stall     = (~busy & icache_read_req & ~hit) | busy;

  icache_refill_fsm u_refill_fsm (
    .clk            (clk),
    .reset          (reset),
    .miss_i         (icache_read_req & ~hit),
    .line_addr_i    ({req_tag, req_idx}),
    .flush_i        (icache_flush),
    .mem_ready_i    (mem_ready),
    .busy_o         (busy),
    .refill_start_o (refill_start),
    .fill_we_o      (fill_we),
    .update_o       (update),
    .update_flush_o (update_flush),
    .miss_addr_o    (miss_addr),
    .word_cnt_o     (word_cnt),
    .mem_read_req_o (mem_read_req),
    .mem_addr_o     (mem_addr)
  );

  always_ff @(posedge clk) begin
    if (fill_we) data_q[wr_ptr] <= mem_read_data;
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    // The victim line goes invalid up front so a partial fill can never hit.
    if (refill_start) valid_d[req_idx] = 1'b0;
    if (update) begin
      if (update_flush) begin
        valid_d = '0;
      end else begin
        valid_d[miss_idx] = 1'b1;
        tag_d[miss_idx]   = miss_tag;
      end
    end
    if (!busy && icache_flush) valid_d = '0;
  end

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (!busy && hit && (hit_count_q != '1)) hit_count_d = hit_count_q + CNT_W'(1);
    if (refill_start && (miss_count_q != '1)) miss_count_d = miss_count_q + CNT_W'(1);
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed self-checking bench for icache_direct_mapped with a small backing
// memory responder whose ready latency is selectable per test.
module tb_icache_direct_mapped;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_read_req;
  logic [11:0] icache_addr;
  logic [31:0] icache_read_data;
  logic        icache_stall;
  logic        icache_flush;
  logic        mem_read_req;
  logic [11:0] mem_addr;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;

  int          ready_delay = 0;
  int          wait_cnt;
  logic [11:0] prev_addr;
  logic [11:0] addr_log[$];

  icache_direct_mapped dut (
    .clk              (clk),
    .reset            (reset),
    .icache_read_req  (icache_read_req),
    .icache_addr      (icache_addr),
    .icache_read_data (icache_read_data),
    .icache_stall     (icache_stall),
    .icache_flush     (icache_flush),
    .mem_read_req     (mem_read_req),
    .mem_addr         (mem_addr),
    .mem_read_data    (mem_read_data),
    .mem_ready        (mem_ready),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  // Word at 0x040 + 4k holds 0xA000_0000 + k (address arithmetic wraps at 12 bits).
  function automatic logic [31:0] mem_word(input logic [11:0] a);
    logic [11:0] d;
    d = a - 12'h040;
    return 32'hA000_0000 + {22'h0, d[11:2]};
  endfunction

  assign mem_read_data = mem_word(mem_addr);
  assign mem_ready     = mem_read_req && (wait_cnt == ready_delay);

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (mem_read_req && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk) begin
    if (!reset && mem_read_req && mem_ready) addr_log.push_back(mem_addr);
  end

  always @(negedge clk) begin
    if (!reset && mem_read_req && wait_cnt != 0) begin
      checks++;
      if (mem_addr !== prev_addr) begin
        errors++;
        $display("FAIL mem_addr_stable: got %h want %h", mem_addr, prev_addr);
      end
    end
    prev_addr = mem_addr;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic start_req(input logic [11:0] a);
    @(posedge clk); #1;
    icache_read_req = 1'b1;
    icache_addr     = a;
  endtask

  task automatic end_req;
    @(posedge clk); #1;
    icache_read_req = 1'b0;
  endtask

  // Counts stalled cycles from the request's first cycle until stall drops.
  task automatic wait_unstall(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (icache_stall && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    icache_read_req = 1'b0;
    icache_addr = '0;
    icache_flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (icache_stall !== 1'b0 || mem_read_req !== 1'b0 || mem_addr !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b req=%b addr=%h want 0 0 000",
               icache_stall, mem_read_req, mem_addr);
    end
    checks++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got hit=%0d miss=%0d want 0 0", hit_count, miss_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_cold_miss;
    int cyc;
    logic [11:0] ea;
    addr_log.delete();
    start_req(12'h040);
    wait_unstall(cyc);
    checks++;
    if (cyc != 6) begin
      errors++;
      $display("FAIL cold_latency: got %0d want 6", cyc);
    end
    checks++;
    if (icache_read_data !== 32'hA000_0000) begin
      errors++;
      $display("FAIL cold_data: got %h want a0000000", icache_read_data);
    end
    checks++;
    if (miss_count !== 16'd1) begin
      errors++;
      $display("FAIL cold_miss_count: got %0d want 1", miss_count);
    end
    for (int k = 0; k < 4; k++) begin
      ea = 12'h040 + 12'(4 * k);
      checks++;
      if (k >= addr_log.size() || addr_log[k] !== ea) begin
        errors++;
        $display("FAIL cold_mem_addr%0d: got %h want %h", k,
                 (k < addr_log.size()) ? addr_log[k] : 12'hxxx, ea);
      end
    end
    end_req;
  endtask

  task automatic test_spatial_hits;
    logic [11:0] addrs [3];
    logic [31:0] exp   [3];
    addrs = '{12'h044, 12'h048, 12'h04C};
    exp   = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    for (int k = 0; k < 3; k++) begin
      start_req(addrs[k]);
      @(negedge clk);
      checks++;
      if (icache_stall !== 1'b0 || icache_read_data !== exp[k]) begin
        errors++;
        $display("FAIL spatial_hit%0d: got stall=%b data=%h want stall=0 data=%h",
                 k, icache_stall, icache_read_data, exp[k]);
      end
    end
    end_req;
    @(negedge clk);
    checks++;
    if (hit_count !== 16'd4) begin
      errors++;
      $display("FAIL spatial_hit_count: got %0d want 4", hit_count);
    end
  endtask

  task automatic test_conflict;
    int cyc;
    start_req(12'h140);
    wait_unstall(cyc);
    checks++;
    if (cyc != 6 || icache_read_data !== 32'hA000_0040) begin
      errors++;
      $display("FAIL conflict_fill: got cyc=%0d data=%h want 6 a0000040", cyc, icache_read_data);
    end
    end_req;
    start_req(12'h040);
    wait_unstall(cyc);
    checks++;
    if (cyc != 6 || icache_read_data !== 32'hA000_0000) begin
      errors++;
      $display("FAIL conflict_evicted: got cyc=%0d data=%h want 6 a0000000",
               cyc, icache_read_data);
    end
    end_req;
    @(negedge clk);
    checks++;
    if (miss_count !== 16'd3 || hit_count !== 16'd6) begin
      errors++;
      $display("FAIL conflict_counts: got miss=%0d hit=%0d want 3 6", miss_count, hit_count);
    end
  endtask

  task automatic test_slow_memory;
    int cyc;
    ready_delay = 2;
    start_req(12'h0C0);
    wait_unstall(cyc);
    checks++;
    if (cyc != 14) begin
      errors++;
      $display("FAIL slow_latency: got %0d want 14", cyc);
    end
    checks++;
    if (icache_read_data !== 32'hA000_0020) begin
      errors++;
      $display("FAIL slow_data0: got %h want a0000020", icache_read_data);
    end
    start_req(12'h0CC);
    @(negedge clk);
    checks++;
    if (icache_stall !== 1'b0 || icache_read_data !== 32'hA000_0023) begin
      errors++;
      $display("FAIL slow_data3: got stall=%b data=%h want 0 a0000023",
               icache_stall, icache_read_data);
    end
    end_req;
    ready_delay = 0;
    @(negedge clk);
    checks++;
    if (miss_count !== 16'd4 || hit_count !== 16'd8) begin
      errors++;
      $display("FAIL slow_counts: got miss=%0d hit=%0d want 4 8", miss_count, hit_count);
    end
  endtask

  task automatic test_flush_refill;
    int cyc;
    int n;
    start_req(12'h080);
    @(posedge clk); #1;
    checks++;
    if (mem_read_req !== 1'b1 || mem_addr !== 12'h080) begin
      errors++;
      $display("FAIL flush_in_refill: got req=%b addr=%h want 1 080", mem_read_req, mem_addr);
    end
    icache_flush = 1'b1;
    @(posedge clk); #1;
    icache_flush = 1'b0;
    icache_read_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (icache_stall && n < 50) begin
      n++;
      @(negedge clk);
    end
    start_req(12'h080);
    wait_unstall(cyc);
    checks++;
    if (cyc != 6 || icache_read_data !== 32'hA000_0010) begin
      errors++;
      $display("FAIL flush_line_invalid: got cyc=%0d data=%h want 6 a0000010",
               cyc, icache_read_data);
    end
    end_req;
    start_req(12'h040);
    wait_unstall(cyc);
    checks++;
    if (cyc != 6) begin
      errors++;
      $display("FAIL flush_other_invalid: got cyc=%0d want 6", cyc);
    end
    end_req;
    @(negedge clk);
    checks++;
    if (miss_count !== 16'd7 || hit_count !== 16'd10) begin
      errors++;
      $display("FAIL flush_counts: got miss=%0d hit=%0d want 7 10", miss_count, hit_count);
    end
  endtask

  task automatic test_flush_idle_hit;
    int cyc;
    @(posedge clk); #1;
    icache_read_req = 1'b1;
    icache_addr = 12'h040;
    icache_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (icache_stall !== 1'b0 || icache_read_data !== 32'hA000_0000) begin
      errors++;
      $display("FAIL flush_same_cycle_hit: got stall=%b data=%h want 0 a0000000",
               icache_stall, icache_read_data);
    end
    @(posedge clk); #1;
    icache_flush = 1'b0;
    icache_read_req = 1'b0;
    start_req(12'h040);
    wait_unstall(cyc);
    checks++;
    if (cyc != 6) begin
      errors++;
      $display("FAIL flush_idle_invalid: got cyc=%0d want 6", cyc);
    end
    end_req;
    @(negedge clk);
    checks++;
    if (miss_count !== 16'd8 || hit_count !== 16'd12) begin
      errors++;
      $display("FAIL flush_idle_counts: got miss=%0d hit=%0d want 8 12", miss_count, hit_count);
    end
  endtask

  task automatic test_reset_mid_refill;
    int cyc;
    start_req(12'h100);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (mem_read_req !== 1'b1 || mem_addr !== 12'h108) begin
      errors++;
      $display("FAIL mid_refill_word2: got req=%b addr=%h want 1 108", mem_read_req, mem_addr);
    end
    reset = 1'b1;
    icache_read_req = 1'b0;
    #1;
    checks++;
    if (mem_read_req !== 1'b0 || icache_stall !== 1'b0) begin
      errors++;
      $display("FAIL mid_refill_abort: got req=%b stall=%b want 0 0", mem_read_req, icache_stall);
    end
    checks++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_refill_counters: got hit=%0d miss=%0d want 0 0", hit_count, miss_count);
    end
    @(negedge clk);
    reset = 1'b0;
    start_req(12'h040);
    wait_unstall(cyc);
    checks++;
    if (cyc != 6 || miss_count !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_miss: got cyc=%0d miss=%0d want 6 1", cyc, miss_count);
    end
    end_req;
  endtask

  task automatic test_saturation;
    start_req(12'h040);
    repeat (65600) @(posedge clk);
    #1;
    checks++;
    if (hit_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL hit_saturate: got %h want ffff", hit_count);
    end
    checks++;
    if (miss_count !== 16'd1) begin
      errors++;
      $display("FAIL saturate_miss_count: got %0d want 1", miss_count);
    end
    end_req;
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_spatial_hits;
    test_conflict;
    test_slow_memory;
    test_flush_refill;
    test_flush_idle_hit;
    test_reset_mid_refill;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
